dm_write_tracer: RTL and testbench



---
 rtl/dm_write_tracer.sv | 99 +++++++++
 tb/tb_dm_write_tracer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_write_tracer.sv
// dm_write_tracer: snoops data-memory writes into a circular (addr, data, timestamp) buffer
// and drains it oldest-first over valid/ready on a rising edge of dump.
module dm_write_tracer #(
   parameter int N            = 64,
   parameter int DEPTH        = 16,
   parameter int TS_W         = 16,
   parameter int STOP_ON_FULL = 0
) (
   input  logic                     CLOCK_50,
   input  logic                     reset,
   input  logic                     DM_writeEnable,
   input  logic [N-1:0]             DM_addr,
   input  logic [N-1:0]             DM_writeData,
   input  logic                     dump,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N-1:0]             out_addr,
   output logic [N-1:0]             out_data,
   output logic [TS_W-1:0]          out_ts,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     dump_done
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]     FULL   = DEPTH;
   localparam logic [AW:0]     ONE_C  = 1;
   localparam logic [AW-1:0]   ONE_P  = 1;
   localparam logic [TS_W-1:0] ONE_TS = 1;

   typedef enum logic [1:0] {CAPTURE, DRAIN, DONE} state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    addr_q  [DEPTH];
   logic [N-1:0]    data_q  [DEPTH];
   logic [TS_W-1:0] stamp_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [TS_W-1:0] ts_q, ts_d;
   logic            dump_q, dump_d, overflow_q, overflow_d, dump_done_q, dump_done_d;
   logic            full, wr_req, wr, pop;

   always_comb begin
      full        = count_q == FULL;
      wr_req      = state_q == CAPTURE && DM_writeEnable;
      wr          = wr_req && !(full && STOP_ON_FULL != 0);
      out_valid   = state_q == DRAIN && count_q != '0;
      pop         = out_valid && out_ready;
      // an overwrite of a full buffer drops the oldest entry, so the read side advances too
      wr_ptr_d    = wr ? wr_ptr_q + ONE_P : wr_ptr_q;
      rd_ptr_d    = (pop || (wr && full)) ? rd_ptr_q + ONE_P : rd_ptr_q;
      count_d     = (wr && !full) ? count_q + ONE_C : pop ? count_q - ONE_C : count_q;
      ts_d        = ts_q + ONE_TS;
      dump_d      = dump;
      overflow_d  = (wr_req && full) ? 1'b1 : (state_q == DONE && !dump) ? 1'b0 : overflow_q;
      state_d     = (state_q == CAPTURE && dump && !dump_q) ? DRAIN :
                    (state_q == DRAIN && count_q == '0)     ? DONE  :
                    (state_q == DONE && !dump)              ? CAPTURE : state_q;
      dump_done_d = state_d == DONE;
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q     <= CAPTURE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ts_q        <= '0;
         dump_q      <= 1'b0;
         overflow_q  <= 1'b0;
         dump_done_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i]  <= '0;
            data_q[i]  <= '0;
            stamp_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ts_q        <= ts_d;
         dump_q      <= dump_d;
         overflow_q  <= overflow_d;
         dump_done_q <= dump_done_d;
         if (wr) begin
            addr_q[wr_ptr_q]  <= DM_addr;
            data_q[wr_ptr_q]  <= DM_writeData;
            stamp_q[wr_ptr_q] <= ts_q;
         end
      end
   end

   assign out_addr  = addr_q[rd_ptr_q];
   assign out_data  = data_q[rd_ptr_q];
   assign out_ts    = stamp_q[rd_ptr_q];
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign dump_done = dump_done_q;
endmodule

// File: tb/tb_dm_write_tracer.sv
// tb_dm_write_tracer: three tracer variants (16-deep, 4-deep overwrite, 4-deep discard)
// share one stimulus stream and are checked every cycle against a queue-based model.
module tb_dm_write_tracer;
   logic        clk = 0, rst_n = 0, we = 0, dump = 0, rdy = 0;
   logic [63:0] a = 0, d = 0;
   always #5 clk = ~clk;

   logic [2:0]  ov, dd, of;
   logic [63:0] oa [3];
   logic [63:0] od [3];
   logic [15:0] ots0;
   logic [3:0]  ots1, ots2;
   logic [4:0]  cnt0;
   logic [2:0]  cnt1, cnt2;
   logic [15:0] ts_u  [3];
   logic [4:0]  cnt_u [3];
   assign ts_u[0]  = ots0;
   assign ts_u[1]  = {12'b0, ots1};
   assign ts_u[2]  = {12'b0, ots2};
   assign cnt_u[0] = cnt0;
   assign cnt_u[1] = {2'b0, cnt1};
   assign cnt_u[2] = {2'b0, cnt2};

   dm_write_tracer #(.N(64), .DEPTH(16), .TS_W(16), .STOP_ON_FULL(0)) u_a (
      .CLOCK_50(clk), .reset(rst_n), .DM_writeEnable(we), .DM_addr(a), .DM_writeData(d),
      .dump(dump), .out_valid(ov[0]), .out_ready(rdy), .out_addr(oa[0]), .out_data(od[0]),
      .out_ts(ots0), .count(cnt0), .overflow(of[0]), .dump_done(dd[0]));
   dm_write_tracer #(.N(64), .DEPTH(4), .TS_W(4), .STOP_ON_FULL(0)) u_b (
      .CLOCK_50(clk), .reset(rst_n), .DM_writeEnable(we), .DM_addr(a), .DM_writeData(d),
      .dump(dump), .out_valid(ov[1]), .out_ready(rdy), .out_addr(oa[1]), .out_data(od[1]),
      .out_ts(ots1), .count(cnt1), .overflow(of[1]), .dump_done(dd[1]));
   dm_write_tracer #(.N(64), .DEPTH(4), .TS_W(4), .STOP_ON_FULL(1)) u_c (
      .CLOCK_50(clk), .reset(rst_n), .DM_writeEnable(we), .DM_addr(a), .DM_writeData(d),
      .dump(dump), .out_valid(ov[2]), .out_ready(rdy), .out_addr(oa[2]), .out_data(od[2]),
      .out_ts(ots2), .count(cnt2), .overflow(of[2]), .dump_done(dd[2]));

   typedef struct {logic [63:0] a; logic [63:0] d; logic [31:0] t;} ent_t;
   ent_t        q [3][$];
   int          mode [3];
   bit          ovf [3];
   bit          dprev;
   int unsigned tsc;
   int          depth [3] = '{16, 4, 4};
   bit          stop  [3] = '{0, 0, 1};
   int          passed = 0, total = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // model: mode 0 capture, 1 drain, 2 done; queue front is the oldest entry
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            q[i].delete();
            mode[i] <= 0;
            ovf[i]  <= 0;
         end
         dprev <= 0;
         tsc   <= 0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (mode[i] == 0) begin
               if (we) begin
                  if (q[i].size() == depth[i]) begin
                     ovf[i] <= 1;
                     if (!stop[i]) begin
                        void'(q[i].pop_front());
                        q[i].push_back('{a, d, tsc});
                     end
                  end else q[i].push_back('{a, d, tsc});
               end
               if (dump && !dprev) mode[i] <= 1;
            end else if (mode[i] == 1) begin
               if (q[i].size() == 0) mode[i] <= 2;
               else if (rdy) void'(q[i].pop_front());
            end else if (!dump) begin
               mode[i] <= 0;
               ovf[i]  <= 0;
            end
         end
         dprev <= dump;
         tsc   <= tsc + 1;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         bit v;
         v = mode[i] == 1 && q[i].size() != 0;
         chk($sformatf("valid%0d", i), ov[i], v);
         chk($sformatf("count%0d", i), cnt_u[i], q[i].size());
         chk($sformatf("overflow%0d", i), of[i], ovf[i]);
         chk($sformatf("dump_done%0d", i), dd[i], mode[i] == 2);
         if (v) begin
            chk($sformatf("addr%0d", i), oa[i], q[i][0].a);
            chk($sformatf("data%0d", i), od[i], q[i][0].d);
            chk($sformatf("ts%0d", i), ts_u[i], q[i][0].t & (i == 0 ? 32'hFFFF : 32'hF));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain_wait();
      int n = 0;
      while (!dd[0] && n < 60) begin
         step();
         n++;
      end
      chk("drain_timeout", dd[0], 1);
   endtask

   initial begin
      step();
      step();
      rst_n = 1;
      // basic capture: writes land at ts=3 and ts=5
      repeat (3) step();
      we = 1; a = 64'h10; d = 64'hAA; step();
      we = 0; step();
      we = 1; a = 64'h18; d = 64'hBB; step();
      we = 0; dump = 1; rdy = 1; step();
      chk("basic_v0", ov[0], 1);
      chk("basic_a0", oa[0], 64'h10);
      chk("basic_d0", od[0], 64'hAA);
      chk("basic_t0", ts_u[0], 3);
      step();
      chk("basic_a1", oa[0], 64'h18);
      chk("basic_d1", od[0], 64'hBB);
      chk("basic_t1", ts_u[0], 5);
      step();
      chk("basic_cnt0", cnt0, 0);
      chk("basic_nodone", dd[0], 0);
      step();
      chk("basic_done", dd[0], 1);
      chk("basic_ovf", of[0], 0);
      dump = 0; step();
      chk("basic_back", dd[0], 0);
      // full-buffer policies
      for (int k = 1; k <= 6; k++) begin
         we = 1; a = 64'(k * 8); d = 64'(k); step();
      end
      we = 0;
      chk("ow_count", cnt1, 4);
      chk("disc_count", cnt2, 4);
      chk("ow_ovf", of[1], 1);
      chk("disc_ovf", of[2], 1);
      chk("big_count", cnt0, 6);
      dump = 1; rdy = 1; step();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("ow_beat%0d", k), od[1], 64'(3 + k));
         chk($sformatf("disc_beat%0d", k), od[2], 64'(1 + k));
         step();
      end
      drain_wait();
      dump = 0; step();
      chk("ow_ovf_clr", of[1], 0);
      chk("disc_ovf_clr", of[2], 0);
      // backpressure with writes ignored during drain
      we = 1;
      for (int k = 0; k < 3; k++) begin
         a = 64'h200 + 64'(k); d = 64'h100 + 64'(k); step();
      end
      we = 0; dump = 1; rdy = 1; step();
      chk("bp_first", od[0], 64'h100);
      step();
      rdy = 0; we = 1; a = 64'hDEAD; d = 64'hBEEF;
      chk("bp_stall0", od[0], 64'h101);
      step();
      chk("bp_stall1", od[0], 64'h101);
      step();
      chk("bp_stall2", od[0], 64'h101);
      rdy = 1; step();
      chk("bp_last", od[0], 64'h102);
      step();
      we = 0;
      drain_wait();
      chk("bp_empty", cnt0, 0);
      dump = 0; step();
      // empty dump
      dump = 1; step();
      chk("empty_v", ov[0], 0);
      chk("empty_nodone", dd[0], 0);
      step();
      chk("empty_done", dd[0], 1);
      chk("empty_v2", ov[0], 0);
      dump = 0; step();
      chk("empty_back", dd[0], 0);
      chk("empty_ovf", of[0], 0);
      // timestamp wrap: writes at ts 15 and 16
      rst_n = 0; step();
      rst_n = 1;
      repeat (15) step();
      we = 1; a = 1; d = 1; step();
      a = 2; d = 2; step();
      we = 0; dump = 1; rdy = 1; step();
      chk("wrap_b15", ts_u[1], 15);
      chk("wrap_a15", ts_u[0], 15);
      step();
      chk("wrap_b0", ts_u[1], 0);
      chk("wrap_a16", ts_u[0], 16);
      drain_wait();
      dump = 0; step();
      // reset mid-drain, with overflow set on the 4-deep variants
      we = 1;
      for (int k = 0; k < 5; k++) begin
         a = 64'h40 + 64'(k); d = 64'h50 + 64'(k); step();
      end
      we = 0; dump = 1; rdy = 0; step();
      chk("mid_valid", ov[0], 1);
      chk("mid_ovf", of[1], 1);
      rst_n = 0; #1;
      chk("rst_valid", ov[0], 0);
      chk("rst_count", cnt0, 0);
      chk("rst_done", dd[0], 0);
      chk("rst_ovf", of[1], 0);
      chk("rst_addr", oa[0], 0);
      chk("rst_data", od[0], 0);
      step();
      rst_n = 1; dump = 0; step();
      // randomized traffic
      repeat (400) begin
         we  = 1'($urandom_range(0, 1));
         a   = {$urandom, $urandom};
         d   = {$urandom, $urandom};
         rdy = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 15) == 0) dump = ~dump;
         step();
      end
      dump = 0;
      repeat (3) step();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
